// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings and control FSM states.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: add-shift for multiply,
// restoring compare-subtract-shift for divide.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [2*WIDTH:0] acc_next
);

  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;

  assign upper = acc[2*WIDTH:WIDTH];
  assign lower = acc[WIDTH-1:0];

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign sum = upper + (lower[0] ? {1'b0, operand} : '0);

  // Divide: acc = {remainder (WIDTH+1), quotient/dividend bits}
  assign shl  = {upper[WIDTH-1:0], lower[WIDTH-1]};
  assign diff = {1'b0, shl} - {2'b00, operand};

  always_comb begin
    acc_next = {1'b0, sum, lower[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH+1])
        acc_next = {shl, lower[WIDTH-2:0], 1'b0};
      else
        acc_next = {diff[WIDTH:0], lower[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and
// MTHI/MTLO writes; one result bit per cycle.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_n;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_step;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic             is_div;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;
  assign b_zero    = (b_q == '0);

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .operand (opnd),
    .is_div  (is_div),
    .acc_next(acc_step)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = PREP;
      PREP: state_n = RUN;
      RUN:  if (cnt == CW'(1)) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sign correction; MIN / -1 falls out naturally as MIN rem 0
  always_comb begin
    prod   = acc[2*WIDTH-1:0];
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = '0;
    res_lo = '0;
    if (!is_div) begin
      if (neg_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? -rem : rem;
      res_lo = neg_q ? -quo : quo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == FIX);
      dbz_q  <= (state_n == FIX) & is_div & b_zero;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end else begin
            if (mthi) hi_q <= wr_data;
            if (mtlo) lo_q <= wr_data;
          end
        end
        PREP: begin
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= CW'(WIDTH);
          if (is_div) begin
            opnd <= b_mag;
            acc  <= {{(WIDTH+1){1'b0}}, a_mag};
          end else begin
            opnd <= a_mag;
            acc  <= {{(WIDTH+1){1'b0}}, b_mag};
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
